pooling_2d_go_done: RTL and testbench

//  Four-phase go/done handshake controller between the CSR domain and the 2D pooling core.

---
 rtl/pooling_2d_pkg.sv | 18 +
 rtl/pooling_2d_go_done_cnt.sv | 39 +++
 rtl/pooling_2d_go_done.sv | 119 +++++++++++
 tb/tb_pooling_2d_go_done.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pooling_2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pooling_2d_pkg
// Description : Shared FSM encodings and defaults for the 2D pooling go/done
//               handshake controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pooling_2d_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_READY = 2'd1;
    localparam logic [1:0] ST_RUN        = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    localparam int CNT_WIDTH_DEFAULT = 32;

endpackage : pooling_2d_pkg
`default_nettype wire

// File: rtl/pooling_2d_go_done_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pooling_2d_go_done_cnt
// Description : Saturating cycle counter with clear, enable and a compare-equal
//               flag against a fixed value.
// Revision    : 1.0 - initial release
// ============================================================================
module pooling_2d_go_done_cnt
    import pooling_2d_pkg::*;
#(
    parameter int               WIDTH     = CNT_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] CMP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_eq
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_eq    = (r_count == CMP_VALUE);

endmodule : pooling_2d_go_done_cnt
`default_nettype wire

// File: rtl/pooling_2d_go_done.sv
`default_nettype none
// ============================================================================
// Module      : pooling_2d_go_done
// Description : Four-phase go/done handshake controller for the 2D pooling
//               core, with run-length counter and optional timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pooling_2d_go_done
    import pooling_2d_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT,
    parameter int TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go_sync,
    output logic                 done,
    output logic                 busy,
    input  logic                 core_ready,
    output logic                 core_start,
    input  logic                 core_done,
    output logic [CNT_WIDTH-1:0] cnt_cycles,
    output logic                 err_timeout
);

    localparam logic [CNT_WIDTH-1:0] c_cmp_value =
        (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_done;
    logic       r_busy;
    logic       r_start;
    logic       r_err;
    logic       w_cnt_clear;
    logic       w_cnt_en;
    logic       w_cnt_eq;
    logic       w_timeout_hit;
    logic       w_done_seen;

    pooling_2d_go_done_cnt #(
        .WIDTH     (CNT_WIDTH),
        .CMP_VALUE (c_cmp_value)
    ) u_cnt (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_count  (cnt_cycles),
        .o_eq     (w_cnt_eq)
    );

    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign w_timeout_hit = w_cnt_eq;
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // The start cycle is the only RUN cycle with r_start set; core_done is blind there.
    assign w_done_seen = (r_state == ST_RUN) && core_done && !r_start;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clear = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go_sync) w_state_nxt = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (core_ready) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_done_seen) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_timeout_hit) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!go_sync) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            r_busy  <= (w_state_nxt == ST_WAIT_READY) || (w_state_nxt == ST_RUN);
            r_start <= (r_state == ST_WAIT_READY) && core_ready;
            if (w_cnt_clear) begin
                r_err <= 1'b0;
            end else if ((r_state == ST_RUN) && !w_done_seen && w_timeout_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign done        = r_done;
    assign busy        = r_busy;
    assign core_start  = r_start;
    assign err_timeout = r_err;

endmodule : pooling_2d_go_done
`default_nettype wire

// File: tb/tb_pooling_2d_go_done.sv
`default_nettype none
// ============================================================================
// Module      : tb_pooling_2d_go_done
// Description : Directed self-checking bench for the go/done controller, with
//               one instance without timeout and one with TIMEOUT=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pooling_2d_go_done;

    logic        clk;
    logic        reset;
    logic        a_go, a_ready, a_cdone;
    logic        a_done, a_busy, a_start, a_err;
    logic [31:0] a_cnt;
    logic        b_go, b_ready, b_cdone;
    logic        b_done, b_busy, b_start, b_err;
    logic [31:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    pooling_2d_go_done #(.CNT_WIDTH(32), .TIMEOUT(0)) dut_a (
        .clk(clk), .reset(reset), .go_sync(a_go), .done(a_done), .busy(a_busy),
        .core_ready(a_ready), .core_start(a_start), .core_done(a_cdone),
        .cnt_cycles(a_cnt), .err_timeout(a_err)
    );

    pooling_2d_go_done #(.CNT_WIDTH(32), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .go_sync(b_go), .done(b_done), .busy(b_busy),
        .core_ready(b_ready), .core_start(b_start), .core_done(b_cdone),
        .cnt_cycles(b_cnt), .err_timeout(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        a_go = 0; a_ready = 0; a_cdone = 0;
        b_go = 0; b_ready = 0; b_cdone = 0;
        tick(2);
        reset = 1'b0;
        check("rst_done",  {31'd0, a_done},  32'd0);
        check("rst_busy",  {31'd0, a_busy},  32'd0);
        check("rst_start", {31'd0, a_start}, 32'd0);
        check("rst_cnt",   a_cnt,            32'd0);
        check("rst_err",   {31'd0, a_err},   32'd0);

        // Test 1: go at cycle 0, core_done at cycle 12.
        a_ready = 1; a_go = 1;
        tick();
        check("t1_c1_busy",  {31'd0, a_busy},  32'd1);
        check("t1_c1_start", {31'd0, a_start}, 32'd0);
        tick();
        check("t1_c2_start", {31'd0, a_start}, 32'd1);
        check("t1_c2_busy",  {31'd0, a_busy},  32'd1);
        pulses = 0;
        for (int c = 3; c <= 12; c++) begin
            tick();
            if (a_start) pulses++;
            if (!a_busy) pulses += 100;
        end
        check("t1_run_quiet", pulses, 32'd0);
        a_cdone = 1;
        tick();
        a_cdone = 0;
        check("t1_done", {31'd0, a_done}, 32'd1);
        check("t1_cnt",  a_cnt,           32'd10);
        check("t1_busy", {31'd0, a_busy}, 32'd0);

        // Test 2: release go, then restart.
        a_go = 0;
        tick();
        check("t2_done_low", {31'd0, a_done}, 32'd0);
        check("t2_cnt_held", a_cnt,           32'd10);
        check("t2_busy",     {31'd0, a_busy}, 32'd0);
        tick();
        a_go = 1;
        tick(2);
        check("t2_restart",   {31'd0, a_start}, 32'd1);
        check("t2_cnt_clear", a_cnt,            32'd0);
        tick(3);
        a_cdone = 1;
        tick();
        a_cdone = 0;
        check("t2_done", {31'd0, a_done}, 32'd1);
        check("t2_cnt",  a_cnt,           32'd3);
        a_go = 0;
        tick();

        // Test 3: core not ready for 5 cycles.
        a_ready = 0; a_go = 1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (a_start) pulses++;
        end
        check("t3_wait_busy",  {31'd0, a_busy}, 32'd1);
        check("t3_no_start",   pulses,          32'd0);
        a_ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (a_start) pulses++;
        end
        check("t3_one_start", pulses, 32'd1);
        a_cdone = 1;
        tick();
        a_cdone = 0;
        check("t3_done", {31'd0, a_done}, 32'd1);
        a_go = 0;
        tick();

        // Test 5: spurious core_done in IDLE and in the start cycle; go drops in RUN.
        a_cdone = 1;
        tick();
        a_cdone = 0;
        check("t5_idle_spur_done", {31'd0, a_done}, 32'd0);
        check("t5_idle_spur_busy", {31'd0, a_busy}, 32'd0);
        a_go = 1;
        tick(2);
        check("t5_start", {31'd0, a_start}, 32'd1);
        a_cdone = 1; a_go = 0;
        tick();
        a_cdone = 0;
        check("t5_startspur_done", {31'd0, a_done}, 32'd0);
        check("t5_startspur_busy", {31'd0, a_busy}, 32'd1);
        tick();
        check("t5_go_drop_busy", {31'd0, a_busy}, 32'd1);
        a_cdone = 1;
        tick();
        a_cdone = 0;
        check("t5_done", {31'd0, a_done}, 32'd1);
        check("t5_cnt",  a_cnt,           32'd2);
        tick();
        check("t5_done_low", {31'd0, a_done}, 32'd0);

        // Test 4: TIMEOUT=8 instance.
        b_go = 1; b_ready = 1;
        tick(2);
        check("t4_start", {31'd0, b_start}, 32'd1);
        tick(7);
        check("t4_pre_done", {31'd0, b_done}, 32'd0);
        check("t4_pre_cnt",  b_cnt,           32'd7);
        tick();
        check("t4_to_done", {31'd0, b_done}, 32'd1);
        check("t4_to_err",  {31'd0, b_err},  32'd1);
        check("t4_to_cnt",  b_cnt,           32'd8);
        b_go = 0;
        tick();
        check("t4_err_held", {31'd0, b_err}, 32'd1);
        check("t4_cnt_held", b_cnt,          32'd8);
        b_go = 1;
        tick(2);
        check("t4_err_clear", {31'd0, b_err}, 32'd0);
        tick(7);
        b_cdone = 1;
        tick();
        b_cdone = 0;
        check("t4_tie_done", {31'd0, b_done}, 32'd1);
        check("t4_tie_err",  {31'd0, b_err},  32'd0);
        b_go = 0;
        tick();

        // Test 6: reset during RUN.
        a_go = 1; a_ready = 1;
        tick(3);
        check("t6_in_run", {31'd0, a_busy}, 32'd1);
        reset = 1;
        tick();
        reset = 0; a_go = 0;
        check("t6_rst_busy", {31'd0, a_busy},  32'd0);
        check("t6_rst_cnt",  a_cnt,            32'd0);
        check("t6_rst_done", {31'd0, a_done},  32'd0);
        a_cdone = 1;
        tick();
        a_cdone = 0;
        check("t6_late_done",  {31'd0, a_done},  32'd0);
        check("t6_late_start", {31'd0, a_start}, 32'd0);
        a_go = 1;
        tick(2);
        check("t6_clean_start", {31'd0, a_start}, 32'd1);
        tick();
        a_cdone = 1;
        tick();
        a_cdone = 0;
        check("t6_clean_done", {31'd0, a_done}, 32'd1);
        check("t6_clean_cnt",  a_cnt,           32'd1);
        a_go = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pooling_2d_go_done
`default_nettype wire
